serial_nibble_deserializer: RTL and testbench

//   Receiving end of the serial shift path. A 4-bit universal shift register drives bits out of
//   its MSB (shift-left) or LSB (shift-right) end; this block samples that stream and

---
 rtl/serial_nibble_deserializer_pkg.sv | 9 +
 rtl/serial_nibble_deserializer_if.sv | 12 +
 rtl/serial_nibble_deserializer_fifo.sv | 44 ++++
 rtl/serial_nibble_deserializer.sv | 70 +++++++
 tb/tb_serial_nibble_deserializer.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/serial_nibble_deserializer_pkg.sv
// deser_pkg: shared defaults, state encoding and sizing helper for the nibble deserializer.
package deser_pkg;
  localparam int DESER_WIDTH_DEF = 4;
  localparam int DESER_DEPTH_DEF = 2;
  typedef enum logic {ST_IDLE, ST_ASSEMBLE} state_t;
  function automatic int bitcnt_w(input int width);
    return $clog2(width);
  endfunction
endpackage

// File: rtl/serial_nibble_deserializer_if.sv
// serial_nibble_deserializer_if: serial input stream plus valid/ready word output.
interface serial_nibble_deserializer_if import deser_pkg::*; #(parameter int WIDTH = DESER_WIDTH_DEF);
  logic             sin;
  logic             sin_valid;
  logic             msb_first;
  logic             sync;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  modport master (output sin, sin_valid, msb_first, sync, out_ready, input out_data, out_valid);
  modport slave  (input sin, sin_valid, msb_first, sync, out_ready, output out_data, out_valid);
endinterface

// File: rtl/serial_nibble_deserializer_fifo.sv
// deser_fifo: pointer-based word FIFO; a push while full is taken only alongside a pop.
module deser_fifo import deser_pkg::*; #(
  parameter int WIDTH = DESER_WIDTH_DEF,
  parameter int DEPTH = DESER_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;
  always_comb begin
    empty_o = cnt_q == '0;
    full_o  = cnt_q == (AW+1)'(DEPTH);
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
    cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    head_o  = empty_o ? '0 : mem_q[rd_q];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end
endmodule

// File: rtl/serial_nibble_deserializer.sv
// serial_nibble_deserializer: reassembles a serial bit stream into words queued for a valid/ready consumer.
module serial_nibble_deserializer import deser_pkg::*; #(
  parameter int WIDTH = DESER_WIDTH_DEF,
  parameter int DEPTH = DESER_DEPTH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_ovf_i,
  output logic busy_o,
  output logic overflow_o,
  serial_nibble_deserializer_if.slave bus
);
  localparam int CW = bitcnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);
  logic [WIDTH-1:0] shreg_q, shreg_d, shift_nx, head;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d, dir, ovf_q, ovf_d;
  logic             last, full, empty, pop, drop;
  state_t           state;
  deser_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (last),
    .push_data_i (shift_nx),
    .full_o      (full),
    .pop_i       (pop),
    .head_o      (head),
    .empty_o     (empty)
  );
  always_comb begin
    state    = cnt_q == '0 ? ST_IDLE : ST_ASSEMBLE;
    dir      = state == ST_IDLE ? bus.msb_first : dir_q;
    shift_nx = dir ? {shreg_q[WIDTH-2:0], bus.sin} : {bus.sin, shreg_q[WIDTH-1:1]};
    last     = bus.sin_valid && !bus.sync && cnt_q == LAST;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    dir_d    = dir_q;
    // sync restarts the frame; a coincident bit becomes the first bit of the new word
    if (bus.sync) begin
      cnt_d   = bus.sin_valid ? CW'(1) : '0;
      shreg_d = !bus.sin_valid ? '0 :
                bus.msb_first ? {{(WIDTH-1){1'b0}}, bus.sin} : {bus.sin, {(WIDTH-1){1'b0}}};
      dir_d   = bus.sin_valid ? bus.msb_first : dir_q;
    end else if (bus.sin_valid) begin
      cnt_d   = last ? '0 : cnt_q + 1'b1;
      shreg_d = last ? '0 : shift_nx;
      dir_d   = dir;
    end
    pop           = !empty && bus.out_ready;
    drop          = last && full && !pop;
    ovf_d         = drop ? 1'b1 : clr_ovf_i ? 1'b0 : ovf_q;
    busy_o        = state == ST_ASSEMBLE;
    overflow_o    = ovf_q;
    bus.out_valid = !empty;
    bus.out_data  = head;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_serial_nibble_deserializer.sv
// tb_serial_nibble_deserializer: directed and random stimulus checked against a queue-based word model.
module tb_serial_nibble_deserializer;
  localparam int W = 4;
  localparam int D = 2;
  logic clk = 0, rst = 1, clr_ovf = 0, busy, ovf;
  int   tests = 0, fails = 0;
  bit         pb[$];
  bit         pdir;
  logic [W-1:0] mq[$];
  bit         movf;
  serial_nibble_deserializer_if #(.WIDTH(W)) bus();
  serial_nibble_deserializer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .clr_ovf_i(clr_ovf), .busy_o(busy), .overflow_o(ovf), .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("out_valid", {31'b0, bus.out_valid}, {31'b0, mq.size() > 0});
    chk("out_data", {28'b0, bus.out_data}, mq.size() > 0 ? {28'b0, mq[0]} : 32'd0);
    chk("busy", {31'b0, busy}, {31'b0, pb.size() > 0});
    chk("overflow", {31'b0, ovf}, {31'b0, movf});
  endtask

  task automatic model_reset();
    pb.delete();
    mq.delete();
    movf = 0;
    pdir = 0;
  endtask

  task automatic step(input bit sv, input bit s, input bit mf, input bit sy, input bit rdy, input bit clr);
    bit pushw, pop, drop;
    logic [W-1:0] w;
    bus.sin_valid = sv; bus.sin = s; bus.msb_first = mf; bus.sync = sy; bus.out_ready = rdy; clr_ovf = clr;
    @(posedge clk);
    pushw = 0;
    w = '0;
    pop = mq.size() > 0 && rdy;
    if (sy) begin
      pb.delete();
      if (sv) begin pb.push_back(s); pdir = mf; end
    end else if (sv) begin
      if (pb.size() == 0) pdir = mf;
      pb.push_back(s);
      if (pb.size() == W) begin
        for (int i = 0; i < W; i++) w[pdir ? W-1-i : i] = pb[i];
        pushw = 1;
        pb.delete();
      end
    end
    drop = pushw && mq.size() == D && !pop;
    if (pop) void'(mq.pop_front());
    if (pushw && !drop) mq.push_back(w);
    movf = drop ? 1'b1 : clr ? 1'b0 : movf;
    #1 compare();
  endtask

  task automatic word(input logic [W-1:0] v, input bit mf, input bit rdy_other, input bit rdy_last);
    for (int i = 0; i < W; i++) step(1, mf ? v[W-1-i] : v[i], mf, 0, i == W-1 ? rdy_last : rdy_other, 0);
  endtask

  initial begin
    bus.sin = 0; bus.sin_valid = 0; bus.msb_first = 0; bus.sync = 0; bus.out_ready = 0;
    model_reset();
    #3;
    chk("rst out_valid", {31'b0, bus.out_valid}, 0);
    chk("rst out_data", {28'b0, bus.out_data}, 0);
    chk("rst busy", {31'b0, busy}, 0);
    chk("rst overflow", {31'b0, ovf}, 0);
    #9 rst = 0;
    // 1: MSB-first 1,0,1,1
    step(1, 1, 1, 0, 1, 0);
    chk("t1 busy bit1", {31'b0, busy}, 1);
    step(1, 0, 1, 0, 1, 0);
    step(1, 1, 1, 0, 1, 0);
    chk("t1 busy bit3", {31'b0, busy}, 1);
    step(1, 1, 1, 0, 1, 0);
    chk("t1 word", {28'b0, bus.out_data}, 32'hB);
    chk("t1 valid", {31'b0, bus.out_valid}, 1);
    step(0, 0, 0, 0, 1, 0);
    // 2: LSB-first 1,0,1,1 then msb_first toggled mid-word
    step(1, 1, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 1, 0);
    step(1, 1, 0, 0, 1, 0);
    chk("t2 word", {28'b0, bus.out_data}, 32'hD);
    step(0, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 1, 0);
    step(1, 1, 1, 0, 1, 0);
    step(1, 0, 1, 0, 1, 0);
    step(1, 0, 1, 0, 1, 0);
    chk("t2 dir latched", {28'b0, bus.out_data}, 32'h3);
    step(0, 0, 0, 0, 1, 0);
    // 3: overflow with stalled consumer
    word(4'h3, 1, 0, 0);
    word(4'h5, 1, 0, 0);
    word(4'h9, 1, 0, 0);
    chk("t3 overflow", {31'b0, ovf}, 1);
    chk("t3 head", {28'b0, bus.out_data}, 32'h3);
    step(0, 0, 0, 0, 1, 0);
    chk("t3 second", {28'b0, bus.out_data}, 32'h5);
    step(0, 0, 0, 0, 1, 0);
    chk("t3 drained", {31'b0, bus.out_valid}, 0);
    chk("t3 ovf sticky", {31'b0, ovf}, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("t3 clr", {31'b0, ovf}, 0);
    // 4: push and pop together while full
    word(4'h3, 1, 0, 0);
    word(4'h5, 1, 0, 0);
    word(4'h9, 1, 0, 1);
    chk("t4 no ovf", {31'b0, ovf}, 0);
    chk("t4 head", {28'b0, bus.out_data}, 32'h5);
    step(0, 0, 0, 0, 1, 0);
    chk("t4 third", {28'b0, bus.out_data}, 32'h9);
    step(0, 0, 0, 0, 1, 0);
    // 5: sync with coincident bit
    step(1, 1, 1, 0, 1, 0);
    step(1, 0, 1, 0, 1, 0);
    step(1, 1, 1, 1, 1, 0);
    chk("t5 busy after sync", {31'b0, busy}, 1);
    step(1, 0, 1, 0, 1, 0);
    step(1, 0, 1, 0, 1, 0);
    chk("t5 no partial", {31'b0, bus.out_valid}, 0);
    step(1, 0, 1, 0, 1, 0);
    chk("t5 word", {28'b0, bus.out_data}, 32'h8);
    step(0, 0, 0, 0, 1, 0);
    chk("t5 single", {31'b0, bus.out_valid}, 0);
    // 6: async reset mid-word with one queued word
    word(4'h6, 1, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    #2 rst = 1;
    #1;
    chk("t6 valid", {31'b0, bus.out_valid}, 0);
    chk("t6 busy", {31'b0, busy}, 0);
    chk("t6 ovf", {31'b0, ovf}, 0);
    chk("t6 data", {28'b0, bus.out_data}, 0);
    model_reset();
    #2 rst = 0;
    word(4'hA, 1, 0, 0);
    chk("t6 word", {28'b0, bus.out_data}, 32'hA);
    step(0, 0, 0, 0, 1, 0);
    chk("t6 single", {31'b0, bus.out_valid}, 0);
    // random traffic against the model
    for (int n = 0; n < 3000; n++)
      step($urandom % 4 != 0, 1'($urandom), 1'($urandom), $urandom % 16 == 0,
           $urandom % 3 != 0, $urandom % 20 == 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
